// File: rtl/prog_loader_mem.sv
// Writable 16x8 program memory for the CPU, filled by a byte-stream loader.
// The loader holds the CPU in reset and releases it only after a good checksum.
module prog_loader_mem (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] addr,
    output logic [7:0] data,
    output logic       cpu_n_reset,
    input  logic       load_req,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  mem_r [16];
    logic [3:0]  wptr_r;
    logic [7:0]  sum_r;
    logic        done_r;
    logic        err_r;

    logic        start_s;
    logic        wr_en_s;
    logic        csum_ok_s;
    logic        csum_bad_s;
    logic        active_s;
    logic        hold_s;

    // Running checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] byte_in);
        csum_add = acc + byte_in;
    endfunction

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        wr_en_s    = 1'b0;
        csum_ok_s  = 1'b0;
        csum_bad_s = 1'b0;
        active_s   = 1'b0;
        hold_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_req) begin
                    state_s = ST_LOAD;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                active_s = 1'b1;
                hold_s   = 1'b1;
                if (wr_valid) begin
                    wr_en_s = 1'b1;
                    if (wptr_r == 4'd15) begin
                        state_s = ST_CSUM;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_CSUM: begin
                active_s = 1'b1;
                hold_s   = 1'b1;
                // The checksum byte is consumed here and never written to memory.
                if (wr_valid) begin
                    if (csum_add(sum_r, wr_data) == 8'h00) begin
                        state_s   = ST_IDLE;
                        csum_ok_s = 1'b1;
                    end else begin
                        state_s    = ST_ERR;
                        csum_bad_s = 1'b1;
                    end
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_ERR: begin
                hold_s = 1'b1;
                if (load_req) begin
                    state_s = ST_LOAD;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write pointer, checksum accumulator and sticky status flags.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wptr_r <= 4'd0;
            sum_r  <= 8'h00;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (start_s) begin
            wptr_r <= 4'd0;
            sum_r  <= 8'h00;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (wr_en_s) begin
            wptr_r <= wptr_r + 4'd1;
            sum_r  <= csum_add(sum_r, wr_data);
        end else if (csum_ok_s) begin
            done_r <= 1'b1;
        end else if (csum_bad_s) begin
            err_r <= 1'b1;
        end else begin
            wptr_r <= wptr_r;
        end
    end

    // Program storage; cleared on reset so the CPU runs a harmless image.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            mem_r[wptr_r] <= wr_data;
        end else begin
            mem_r[wptr_r] <= mem_r[wptr_r];
        end
    end

    assign data        = mem_r[addr];
    assign cpu_n_reset = n_reset & ~hold_s;
    assign wr_ready    = n_reset & active_s;
    assign busy        = n_reset & active_s;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: doc/prog_loader_mem.md
# prog_loader_mem

Writable 16×8 program memory with a byte-stream loader, replacing the fixed program table on the board. It sits directly upstream of the `cpu`: the CPU's 4-bit `addr` selects an 8-bit instruction `data`. A `load_req` pulse starts a load. The loader holds the CPU in reset, accepts 16 instruction bytes plus one checksum byte over a valid/ready handshake, then releases the CPU only if the checksum passes.

## Interface
- No parameters; the depth (16) and width (8) are fixed by the CPU's address and instruction widths.
- `clk`  in  1  system clock; all state changes on the rising edge
- `n_reset`  in  1  synchronous, active-low reset
- `addr`  in  4  instruction address from the CPU
- `data`  out  8  instruction to the CPU; combinational read, `mem[addr]`
- `cpu_n_reset`  out  1  reset to the CPU; combinational, `n_reset & ~hold`
- `load_req`  in  1  single-cycle request to start a program load
- `wr_valid`  in  1  loader byte valid
- `wr_data`  in  8  loader byte
- `wr_ready`  out  1  block accepts a byte; high in LOAD and CSUM
- `busy`  out  1  high in LOAD and CSUM
- `done`  out  1  sticky; set when a load completes with a good checksum
- `err`  out  1  sticky; set when a load ends with a bad checksum

## Operation
- **Handshake.** A byte transfers on a rising edge where `wr_valid & wr_ready` is high. `wr_data` is ignored at all other times.
- **State IDLE** (`hold` = 0, CPU runs):
  - `load_req` = 1 → LOAD.
  - On that entry: `wptr` = 0, `sum` = 0x00, `done` = 0, `err` = 0.
- **State LOAD** (`hold` = 1):
  - Each transfer writes `mem[wptr] <= wr_data`, then `sum <= sum + wr_data` (mod 256), then `wptr <= wptr + 1`.
  - The transfer with `wptr` = 15 → CSUM. `wptr` wraps to 0 and is unused afterwards.
- **State CSUM** (`hold` = 1):
  - The next transfer is the checksum byte; it is not written to memory.
  - If `(sum + wr_data) mod 256 == 0x00` → IDLE with `done` = 1.
  - Otherwise → ERR with `err` = 1.
- **State ERR** (`hold` = 1, CPU stays in reset):
  - `load_req` = 1 → LOAD, clearing `done`, `err`, `wptr` and `sum` as from IDLE.
- **`load_req` edge cases.** Ignored in LOAD and CSUM. A `load_req` in the same cycle as the final checksum transfer is also ignored.
- **CPU read path.** `data = mem[addr]` in every state.
  - During a load the CPU is held in reset, so reads of partial contents have no effect.
  - After ERR the memory keeps the partially written or bad image.
- **Reset** (`n_reset` = 0 on an edge), including mid-load:
  - state = IDLE; `wptr` = 0; `sum` = 0; `done` = 0; `err` = 0.
  - All 16 words = 0x00.
- **Outputs while `n_reset` is low:** `cpu_n_reset` = 0, `wr_ready` = 0, `busy` = 0.
- **Boundary rules:**
  - Back-to-back transfers every cycle must be accepted with no bubbles.
  - Gaps in `wr_valid` of any length stall the load indefinitely; there is no timeout.

## Timing
- **Load start.** `load_req` sampled high at edge N (in IDLE or ERR):
  - `busy`, `wr_ready` = 1 after edge N.
  - `cpu_n_reset` = 0 after edge N, so the CPU sees reset from the next edge.
- **Memory write.** A transfer at edge M updates `mem`; `data` reflects the new word combinationally after edge M.
- **Successful checksum.** Checksum transfer at edge K:
  - After edge K: `busy` = 0, `wr_ready` = 0, `done` = 1.
  - After edge K: `cpu_n_reset` = `n_reset`, so the CPU starts from address 0 on edge K+1.
- **Minimum load time:** 17 cycles from the first accepted byte to release.
- **Reset exit.** First edge with `n_reset` = 1 → IDLE; `cpu_n_reset` = 1 immediately, and the CPU executes the zeroed memory (0x00 = ADD A,0).

## Test plan
- **Reset.** Hold `n_reset` = 0 for 2 cycles → `data` = 0x00 for all 16 addresses; `done` = `err` = `busy` = `cpu_n_reset` = 0; `wr_ready` = 0.
- **Good load.** `load_req`, then stream 60 90 3D 01 E3 51 E1 B0 BF F7 + six 00, then checksum 0x57, all back-to-back:
  - `wr_ready` is high for exactly 17 cycles.
  - `done` = 1, `err` = 0, `cpu_n_reset` = 1.
  - `addr` = 4 → `data` = 0xE3; `addr` = 9 → 0xF7; `addr` = 15 → 0x00.
- **Bad checksum.** Same stream with checksum 0x58:
  - `err` = 1, `done` = 0, `cpu_n_reset` stays 0.
  - A second `load_req` with checksum 0x57 → `done` = 1, `err` = 0, CPU released.
- **Stalls.** Random `wr_valid` gaps of 0–5 cycles, plus a `load_req` pulse mid-stream → same final memory and `done` as the good load; the mid-stream `load_req` has no effect.
- **Reset mid-load.** Assert `n_reset` = 0 after 7 bytes → state IDLE, all words 0x00, `busy` = 0. A fresh good load then succeeds.
- **Run after load.** After the good load, run the CPU with `pin_switch` = 4'b0101 → LED output follows the loaded program: 0101 first, then increments until the carry, then alternates 0000 and 1111.
